// File: rtl/mc_program_loader.sv
// mc_program_loader: control sequencer for the MC14500B core.
// Streams a program image into the text RAM (valid/ready, 1 word/cycle,
// 1-cycle write latency), then gates core execution via cpu_hold/cpu_clk_en
// (hold / run / single-step).
// Optional feature: define MC_LOADER_CHECKSUM_EN to add the load_checksum
// output and expect_checksum input (image checksum verified at end of load).
module mc_program_loader #(
    parameter int ADDR_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
    parameter int PROG_DEPTH        = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  halt_req,
    input  logic                  run_req,
    input  logic                  step_req,
    output logic                  prog_write,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_cmd,
    output logic                  cpu_hold,
    output logic                  cpu_clk_en,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error,
`ifdef MC_LOADER_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0] expect_checksum,
    output logic [DATA_WIDTH-1:0] load_checksum,
`endif
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int            CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(PROG_DEPTH);

    typedef enum logic [2:0] {
        S_HALT,
        S_LOAD,
        S_FLUSH,
        S_RUN,
        S_STEP
    } state_e;

    state_e                  state_q, state_d;
    logic                    prog_write_q, prog_write_d;
    logic [ADDR_WIDTH-1:0]   prog_addr_q, prog_addr_d;
    logic [DATA_WIDTH-1:0]   prog_cmd_q, prog_cmd_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    cpu_clk_en_q, cpu_clk_en_d;
    logic                    load_done_q, load_done_d;
    logic                    load_error_q, load_error_d;
    logic [CW-1:0]           word_count_q, word_count_d;
`ifdef MC_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;
`endif
    logic                    go_load;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        prog_write_d = 1'b0;
        prog_addr_d  = prog_addr_q;
        prog_cmd_d   = prog_cmd_q;
        cpu_hold_d   = cpu_hold_q;
        cpu_clk_en_d = cpu_clk_en_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
        word_count_d = word_count_q;
`ifdef MC_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        go_load      = 1'b0;

        case (state_q)
            S_HALT: begin
                cpu_clk_en_d = 1'b0;
                if (load_start) begin
                    go_load = 1'b1;
                end else if (halt_req) begin
                    state_d = S_HALT;
                end else if (run_req) begin
                    state_d      = S_RUN;
                    cpu_hold_d   = 1'b0;
                    cpu_clk_en_d = 1'b1;
                end else if (step_req) begin
                    state_d      = S_STEP;
                    cpu_hold_d   = 1'b0;
                    cpu_clk_en_d = 1'b1;
                end
            end
            S_LOAD: begin
                // load_ready is 1 for the whole of LOAD, so valid alone is the handshake.
                if (load_valid) begin
                    if (word_count_q == DEPTH_C) begin
                        // Overflow is checked before the write so prog_addr never wraps.
                        load_error_d = 1'b1;
                        state_d      = S_HALT;
                    end else begin
                        prog_write_d = 1'b1;
                        prog_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                        prog_cmd_d   = load_data;
                        word_count_d = word_count_q + CW'(1);
`ifdef MC_LOADER_CHECKSUM_EN
                        checksum_d   = checksum_q + load_data;
`endif
                        if (load_last) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                state_d     = S_HALT;
                load_done_d = 1'b1;
`ifdef MC_LOADER_CHECKSUM_EN
                if (checksum_q != expect_checksum) begin
                    load_error_d = 1'b1;
                end
`endif
            end
            S_RUN: begin
                if (load_start) begin
                    go_load = 1'b1;
                end else if (halt_req) begin
                    state_d      = S_HALT;
                    cpu_clk_en_d = 1'b0;
                end else begin
                    cpu_hold_d   = 1'b0;
                    cpu_clk_en_d = 1'b1;
                end
            end
            S_STEP: begin
                state_d      = S_HALT;
                cpu_clk_en_d = 1'b0;
            end
            default: begin
                state_d      = S_HALT;
                cpu_hold_d   = 1'b1;
                cpu_clk_en_d = 1'b0;
            end
        endcase

        if (go_load) begin
            state_d      = S_LOAD;
            word_count_d = '0;
            load_error_d = 1'b0;
            cpu_hold_d   = 1'b1;
            cpu_clk_en_d = 1'b0;
`ifdef MC_LOADER_CHECKSUM_EN
            checksum_d   = '0;
`endif
        end
    end

    // State and registered outputs; reset parks the core in hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HALT;
            prog_write_q <= 1'b0;
            prog_addr_q  <= '0;
            prog_cmd_q   <= '0;
            cpu_hold_q   <= 1'b1;
            cpu_clk_en_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= '0;
`ifdef MC_LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            prog_write_q <= prog_write_d;
            prog_addr_q  <= prog_addr_d;
            prog_cmd_q   <= prog_cmd_d;
            cpu_hold_q   <= cpu_hold_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            word_count_q <= word_count_d;
`ifdef MC_LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign load_ready = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign prog_write = prog_write_q;
    assign prog_addr  = prog_addr_q;
    assign prog_cmd   = prog_cmd_q;
    assign cpu_hold   = cpu_hold_q;
    assign cpu_clk_en = cpu_clk_en_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign word_count = word_count_q;
`ifdef MC_LOADER_CHECKSUM_EN
    assign load_checksum = checksum_q;
`endif

endmodule

// File: doc/mc_program_loader.md
Name: mc_program_loader

Overview:
- Control sequencer for the MC14500B core: loads a program image word-by-word into the text RAM over a valid/ready stream, then gates core execution (hold / run / single-step).
- Sits between a host/debug interface and the core wrapper.
- Drives the text RAM write port (prog_write/prog_addr/prog_cmd) and the core's hold and clock-enable qualifiers.

Parameters:
ADDR_WIDTH, 8, text RAM address width
INSTRUCTION_WIDTH, 4, opcode field width
DATA_WIDTH, ADDR_WIDTH+INSTRUCTION_WIDTH, program word width
PROG_DEPTH, 2**ADDR_WIDTH, maximum words accepted per load

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
load_start  in  1  1-cycle pulse: begin new program load
load_valid  in  1  load_data/load_last valid
load_ready  out  1  loader accepts a word this cycle
load_data  in  DATA_WIDTH  program word {opcode, address}
load_last  in  1  marks final word of image
halt_req  in  1  stop core execution
run_req  in  1  start free-running execution
step_req  in  1  execute exactly one core cycle
prog_write  out  1  text RAM write strobe
prog_addr  out  ADDR_WIDTH  text RAM write address
prog_cmd  out  DATA_WIDTH  text RAM write data
cpu_hold  out  1  holds core PC/ICU in reset when 1
cpu_clk_en  out  1  core clock enable
busy  out  1  1 while in LOAD or FLUSH
load_done  out  1  1-cycle pulse after final write
load_error  out  1  sticky overflow flag, cleared by load_start
word_count  out  ADDR_WIDTH+1  words written in current/last load

Behaviour:
- States: HALT, LOAD, FLUSH, RUN, STEP. Reset asserted → HALT, and every output becomes 0 except cpu_hold=1. word_count=0.
- Command priority when several arrive in one cycle: load_start > halt_req > run_req > step_req.
- HALT: cpu_clk_en=0.
  - load_start → LOAD.
  - run_req → RUN.
  - step_req → STEP.
- LOAD:
  - Entry sets word_count=0, load_error=0, cpu_hold=1, cpu_clk_en=0. load_ready=1 throughout LOAD.
  - A word is accepted on the edge where load_valid & load_ready = 1.
  - The cycle after acceptance: prog_write=1, prog_addr=word_count[ADDR_WIDTH-1:0], prog_cmd=accepted data. word_count increments on the same edge. Throughput is 1 word/cycle; write latency is 1 cycle.
  - Accepted word with load_last=1 → FLUSH.
  - Accepted word while word_count==PROG_DEPTH → word not written, load_error=1, state → HALT, busy drops.
  - load_start, run_req, step_req and halt_req are ignored in LOAD.
- FLUSH:
  - Final prog_write cycle. load_ready=0.
  - Next edge: load_done=1 for 1 cycle, state → HALT.
  - cpu_hold stays 1 so the core starts from address 0.
- RUN:
  - cpu_hold=0 and cpu_clk_en=1 from the cycle after entry.
  - halt_req → HALT; cpu_clk_en=0 next cycle, cpu_hold stays 0 so core state is preserved.
  - load_start → LOAD; cpu_hold=1 next cycle.
- STEP:
  - cpu_hold=0, cpu_clk_en=1 for exactly one cycle, then → HALT.
  - Requests arriving during STEP are dropped.
- cpu_hold deasserts only on entry to RUN or STEP. It reasserts only in LOAD or on reset.
- prog_write is never 1 outside the cycle following an accepted word.
- prog_addr wraps never: the overflow check precedes the write.
- Reset mid-load: prog_write drops asynchronously, partial image stays in RAM, load_done is not pulsed.

Optional Feature:
- Macro MC_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output load_checksum [DATA_WIDTH-1:0]: modulo-2^DATA_WIDTH sum of all words written in the current load. Cleared on load_start and on reset.
  - Adds input expect_checksum [DATA_WIDTH-1:0]. In FLUSH, if the final sum ≠ expect_checksum: load_error=1 and load_done is still pulsed.
- Undefined: neither port exists; no checksum logic is present.

Test Plan:
- Reset low mid-operation → all outputs 0 except cpu_hold=1; state HALT; word_count=0.
- load_start, then 3 back-to-back words 0x1FF, 0xA05, 0x3C0 (last on the 3rd) → prog_write on 3 consecutive cycles at addr 0,1,2; load_done 1 cycle after the 3rd write; word_count=3; cpu_hold=1.
- load_valid toggled every other cycle for 4 words → 4 writes, each exactly 1 cycle after its handshake; addresses 0..3 with no gaps.
- PROG_DEPTH=4, send 5 words with no load_last → 4 writes; 5th dropped; load_error=1; state HALT; no load_done.
- After a load: step_req → cpu_clk_en high exactly 1 cycle, cpu_hold=0. Then run_req and halt_req in the same cycle → halt wins and cpu_clk_en stays 0. Then run_req alone → cpu_clk_en stays 1 until halt_req.
- In RUN, load_start and run_req in the same cycle → LOAD entered; cpu_hold=1 and cpu_clk_en=0 next cycle; load_ready=1.
